// File: rtl/qsys_block_nios2e_oci_pkg.sv
// qsys_block_nios2e_oci_pkg: shared jdo field positions, control bits and state/op encodings
package qsys_block_nios2e_oci_pkg;
    localparam int JDO_CLR_BIT   = 35;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int CTRL_READY    = 0;
    localparam int CTRL_ERROR    = 1;
    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_WR, OP_RD} op_t;
endpackage

// File: rtl/qsys_block_nios2e_oci_ram.sv
// qsys_block_nios2e_oci_ram: single-port synchronous RAM, 1-cycle read latency, byte enables
module qsys_block_nios2e_oci_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);
    logic [31:0] mem [2**ADDR_W];
    // Byte-masked write; registered read returns the pre-write word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        q <= mem[addr];
    end
endmodule

// File: rtl/qsys_block_nios2e_oci_mem_ctrl.sv
// qsys_block_nios2e_oci_mem_ctrl: arbitrates JTAG debug ops and CPU Avalon accesses onto the debug RAM
module qsys_block_nios2e_oci_mem_ctrl
    import qsys_block_nios2e_oci_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              jtag_overrun
);
    localparam int ADDR_MSB = JDO_ADDR_LSB + ADDR_W - 1;

    state_t                          state;
    op_t                             pend_op;
    logic                            pend_valid;
    logic [JDO_CLR_BIT:JDO_ADDR_LSB] pend_data;
    logic [ADDR_W-1:0]               mon_a_reg, ram_addr, pend_addr;
    logic [31:0]                     rdata_reg, ram_q, ram_wdata, ctrl_word;
    logic [3:0]                      ram_be;
    logic strobe, is_ctrl, exec, exec_load, exec_wr, jtag_rd, jtag_clr;
    logic cpu_idle, c_start, grant, ram_wr, ctrl_wr;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:JDO_CLR_BIT+1], jdo[JDO_ADDR_LSB-1:0]};
    assign strobe     = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    assign is_ctrl    = avs_address[ADDR_W];
    assign pend_addr  = pend_data[ADDR_MSB:JDO_ADDR_LSB];
    assign exec       = (state == IDLE) && pend_valid;
    assign exec_load  = exec && (pend_op == OP_LOAD);
    assign exec_wr    = exec && (pend_op == OP_WR);
    assign jtag_rd    = exec && ((pend_op == OP_RD) || ((pend_op == OP_LOAD) && pend_data[JDO_RD_BIT]));
    assign jtag_clr   = exec_load && pend_data[JDO_CLR_BIT];
    assign cpu_idle   = (state == IDLE) && !pend_valid;
    // A strobe arriving with a CPU RAM read is serviced first so the read observes it
    assign c_start    = cpu_idle && !strobe && avs_read && !is_ctrl;
    assign grant      = (state == C_RD) || (cpu_idle && (avs_write || is_ctrl));
    assign avs_waitrequest = (avs_read || avs_write) && !grant;
    assign ctrl_wr    = cpu_idle && avs_write && is_ctrl;
    assign ram_wr     = !reset && (exec_wr || (cpu_idle && avs_write && !is_ctrl));
    assign ram_addr   = exec_load ? pend_addr : exec ? mon_a_reg : avs_address[ADDR_W-1:0];
    assign ram_be     = exec ? 4'hF : avs_byteenable;
    assign ram_wdata  = exec ? pend_data[JDO_WDATA_LSB+31:JDO_WDATA_LSB] : avs_writedata;
    assign avs_readdata = is_ctrl ? ctrl_word : (state == C_RD) ? ram_q : rdata_reg;

    // Control register read view
    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_READY] = monitor_ready;
        ctrl_word[CTRL_ERROR] = monitor_error;
    end

    qsys_block_nios2e_oci_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_wr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Sequencer: JTAG op first, then CPU RAM read; read states last one cycle
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= (state != IDLE) ? IDLE : jtag_rd ? J_RD : c_start ? C_RD : IDLE;
    end

    // One-deep JTAG command slot; strobes hitting a full slot are dropped and flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid   <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            pend_valid   <= (strobe && !pend_valid) || (pend_valid && !exec);
            jtag_overrun <= jtag_overrun || (strobe && pend_valid);
            if (strobe && !pend_valid) begin
                pend_op   <= take_action_ocimem_b ? OP_WR : take_action_ocimem_a ? OP_LOAD : OP_RD;
                pend_data <= jdo[JDO_CLR_BIT:JDO_ADDR_LSB];
            end
        end
    end

    // Address register, read-data capture and monitor flags (JTAG clear beats CPU set)
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            rdata_reg     <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (exec) mon_a_reg <= exec_load ? pend_addr : mon_a_reg + ADDR_W'(1);
            if (state == J_RD) MonDReg <= ram_q;
            if (state == C_RD) rdata_reg <= ram_q;
            monitor_ready <= !jtag_clr && (monitor_ready || (ctrl_wr && avs_writedata[CTRL_READY]));
            monitor_error <= !jtag_clr && (monitor_error || (ctrl_wr && avs_writedata[CTRL_ERROR]));
        end
    end
endmodule

// File: tb/tb_qsys_block_nios2e_oci_mem_ctrl.sv
// tb_qsys_block_nios2e_oci_mem_ctrl: scoreboard bench with a word-level reference model
module tb_qsys_block_nios2e_oci_mem_ctrl;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tn_a;
    logic [AW:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata, MonDReg;
    logic        avs_waitrequest, monitor_ready, monitor_error, jtag_overrun;

    qsys_block_nios2e_oci_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, wcnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] d; int waits; } cexp_t;
    typedef struct { logic [31:0] d; int due; }   jexp_t;
    cexp_t cpu_q[$];
    jexp_t j_q[$];
    cexp_t ce;
    jexp_t je;

    // Reference model state
    logic [31:0] mem [256];
    logic [7:0]  m_a;
    logic        m_rdy, m_err, m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: CPU read completions and JTAG read results against queued expectations
    always @(negedge clk) begin
        if (!reset) begin
            if (avs_read && avs_waitrequest) wcnt++;
            else if (avs_read) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected_read", 32'd1, 32'd0);
                else begin
                    ce = cpu_q.pop_front();
                    chk("cpu_readdata", avs_readdata, ce.d);
                    chk("cpu_wait_cycles", wcnt, ce.waits);
                end
                wcnt = 0;
            end else wcnt = 0;
            if (j_q.size() != 0 && cyc == j_q[0].due) begin
                je = j_q.pop_front();
                chk("MonDReg", MonDReg, je.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jl(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = {$urandom, $urandom};
        j[9:2] = a;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jw(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 address load, 1 write, 2 read-next; n is the cycle of the sampling edge
    task automatic model_jtag(input int kind, input logic [37:0] j, input int n);
        if (kind == 0) begin
            m_a = j[9:2];
            if (j[35]) begin m_rdy = 0; m_err = 0; end
            if (j[34]) j_q.push_back('{mem[m_a], n + 2});
        end else if (kind == 1) begin
            mem[m_a] = j[34:3];
            m_a++;
        end else begin
            j_q.push_back('{mem[m_a], n + 2});
            m_a++;
        end
    endtask

    task automatic jtag_op(input int kind, input logic [37:0] j);
        jdo = j; ta_a = (kind == 0); ta_b = (kind == 1); tn_a = (kind == 2);
        tick();
        ta_a = 0; ta_b = 0; tn_a = 0;
        model_jtag(kind, j, cyc);
        repeat (3) tick();
    endtask

    task automatic cpu_write(input logic [AW:0] a, input logic [31:0] d, input logic [3:0] be);
        int k = 0;
        avs_write = 1; avs_address = a; avs_writedata = d; avs_byteenable = be;
        #1;
        while (avs_waitrequest && k < 20) begin tick(); #1; k++; end
        chk("cpu_write_waits", k, 0);
        tick();
        avs_write = 0;
        if (a[AW]) begin
            m_rdy = m_rdy | d[0];
            m_err = m_err | d[1];
        end else
            for (int i = 0; i < 4; i++) if (be[i]) mem[a[AW-1:0]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic cpu_read(input logic [AW:0] a, input int waits);
        int k = 0;
        cpu_q.push_back('{a[AW] ? {30'b0, m_err, m_rdy} : mem[a[AW-1:0]], waits});
        avs_read = 1; avs_address = a;
        #1;
        while (avs_waitrequest && k < 20) begin tick(); #1; k++; end
        tick();
        avs_read = 0;
    endtask

    initial begin #500000; $display("FAIL global_timeout"); $fatal(1); end

    initial begin
        logic [7:0]  x, t;
        logic [37:0] j;
        reset = 1; jdo = '0; ta_a = 0; ta_b = 0; tn_a = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
        m_a = 0; m_rdy = 0; m_err = 0; m_ovr = 0;
        repeat (3) tick();
        chk("rst_MonDReg", MonDReg, 0);
        chk("rst_readdata", avs_readdata, 0);
        chk("rst_ready", monitor_ready, 0);
        chk("rst_error", monitor_error, 0);
        chk("rst_overrun", jtag_overrun, 0);
        chk("rst_waitrequest", avs_waitrequest, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 256; i++) cpu_write({1'b0, 8'(i)}, $urandom, 4'hF);

        // JTAG load + three writes, then read them back (also proves address ended at 0x13)
        jtag_op(0, jl(8'h10, 0, 0));
        jtag_op(1, jw(32'h11111111));
        jtag_op(1, jw(32'h22222222));
        jtag_op(1, jw(32'h33333333));
        jtag_op(2, '0);
        jtag_op(0, jl(8'h10, 1, 0));
        jtag_op(2, '0);
        jtag_op(2, '0);

        // Address wrap at 0xFF
        jtag_op(0, jl(8'hFF, 0, 0));
        jtag_op(2, '0);
        jtag_op(2, '0);

        // CPU RAM read colliding with a JTAG write to the same address
        x = m_a;
        j = jw($urandom);
        jdo = j; ta_b = 1; avs_read = 1; avs_address = {1'b0, x};
        tick();
        ta_b = 0;
        model_jtag(1, j, cyc);
        cpu_q.push_back('{mem[x], 3});
        begin
            int k = 0;
            #1;
            while (avs_waitrequest && k < 20) begin tick(); #1; k++; end
        end
        tick();
        avs_read = 0;
        tick();

        // Control register set, then CPU set racing a JTAG clear
        cpu_write({1'b1, 8'h0}, 32'h3, 4'hF);
        chk("ctrl_ready_set", monitor_ready, 1);
        chk("ctrl_error_set", monitor_error, 1);
        cpu_read({1'b1, 8'h0}, 0);
        j = jl(8'h20, 0, 1);
        jdo = j; ta_a = 1; avs_write = 1; avs_address = {1'b1, 8'h0}; avs_writedata = 32'h1;
        tick();
        ta_a = 0; avs_write = 0;
        m_rdy = 1;
        model_jtag(0, j, cyc);
        repeat (3) tick();
        chk("race_ready", monitor_ready, 0);
        chk("race_error", monitor_error, 0);
        cpu_read({1'b1, 8'h0}, 0);

        // Two strobes while a CPU read sits in its data cycle: second one is dropped
        x = 8'($urandom);
        cpu_q.push_back('{mem[x], 1});
        avs_read = 1; avs_address = {1'b0, x};
        tick();
        tn_a = 1; jdo = '0;
        tick();
        avs_read = 0; tn_a = 0;
        model_jtag(2, '0, cyc);
        ta_a = 1; jdo = jl(8'h55, 1, 0);
        tick();
        ta_a = 0;
        m_ovr = 1;
        repeat (3) tick();
        chk("overrun_set", jtag_overrun, 1);
        jtag_op(2, '0);
        chk("overrun_sticky", jtag_overrun, 1);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 6))
                0: jtag_op(0, jl(8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0));
                1: jtag_op(1, jw($urandom));
                2: jtag_op(2, '0);
                3: cpu_write({1'b0, 8'($urandom)}, $urandom, 4'($urandom));
                4: cpu_read({1'b0, 8'($urandom)}, 1);
                5: cpu_write({1'b1, 8'($urandom)}, $urandom, 4'hF);
                default: cpu_read({1'b1, 8'($urandom)}, 0);
            endcase
            chk("rand_ready", monitor_ready, m_rdy);
            chk("rand_error", monitor_error, m_err);
            chk("rand_overrun", jtag_overrun, m_ovr);
        end

        // Reset during the execute cycle of a JTAG write suppresses it
        t = m_a;
        j = jw(~mem[t]);
        jdo = j; ta_b = 1; avs_address = '0;
        tick();
        ta_b = 0; reset = 1;
        tick();
        reset = 0;
        m_a = 0; m_rdy = 0; m_err = 0; m_ovr = 0;
        chk("reset_MonDReg", MonDReg, 0);
        chk("reset_readdata", avs_readdata, 0);
        chk("reset_overrun", jtag_overrun, 0);
        chk("reset_ready", monitor_ready, 0);
        jtag_op(2, '0);
        jtag_op(0, jl(t, 1, 0));
        repeat (4) tick();

        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("jtag_queue_drained", j_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
